// File: rtl/lucky_ring_pkg.sv
// Shared helpers for the lucky ring puzzle: adjacency rule and solved check.
package lucky_ring_pkg;

  // Upper bound on ring size for the flattened board used by identity_board.
  localparam int MAX_CELLS = 64;
  localparam int MAX_IDX_W = 6;
  localparam int FLAT_W    = MAX_CELLS * MAX_IDX_W;

  // Adjacency between two cell indices. Plain integer compares, so a
  // neighbour across the N-1/0 seam only counts when wrap is enabled.
  function automatic bit is_adjacent(
    input int f,
    input int t,
    input int n,
    input bit wrap,
    input bit chord
  );
    bit adj;
    adj = 1'b0;
    if ((f == t + 1) || (t == f + 1)) begin
      adj = 1'b1;
    end
    if (wrap && (((f == n - 1) && (t == 0)) || ((f == 0) && (t == n - 1)))) begin
      adj = 1'b1;
    end
    if (chord && (((f == 0) && (t == n / 2)) || ((f == n / 2) && (t == 0)))) begin
      adj = 1'b1;
    end
    return adj;
  endfunction

  // True when every one of the first n cells holds its own index.
  // Cells are packed MAX_IDX_W bits apiece, cell 0 in the low slot.
  function automatic bit identity_board(
    input logic [FLAT_W-1:0] flat,
    input int                n
  );
    bit ok;
    ok = 1'b1;
    for (int i = 0; i < MAX_CELLS; i++) begin
      if (i < n) begin
        if (flat[i*MAX_IDX_W +: MAX_IDX_W] != MAX_IDX_W'(i)) begin
          ok = 1'b0;
        end
      end
    end
    return ok;
  endfunction

endpackage

// File: rtl/lucky_ring_puzzle_adj.sv
// Move validity: destination must be the blank and the two cells adjacent.
module lucky_ring_puzzle_adj
  import lucky_ring_pkg::*;
#(
  parameter int N     = 8,
  parameter int WRAP  = 0,
  parameter int CHORD = 1,
  localparam int W    = $clog2(N)
) (
  input  logic [W-1:0] i_freg,
  input  logic [W-1:0] i_treg,
  input  logic [W-1:0] i_blank,
  output logic         o_valid
);

  logic w_to_blank;
  logic w_adjacent;

  // Board contents are never consulted; only indices and the blank pointer.
  always_comb begin
    w_to_blank = (i_treg == i_blank);
    w_adjacent = is_adjacent(32'(i_freg), 32'(i_treg), N, (WRAP != 0), (CHORD != 0));
    o_valid    = w_to_blank && w_adjacent;
  end

endmodule

// File: rtl/lucky_ring_puzzle.sv
// N-cell sliding-tile ring. Tile 0 is the blank; a move slides the tile at
// `from` into the blank at `to`. Requests are latched one edge and applied
// on the next, so each request sees the board left by the previous edge.
module lucky_ring_puzzle
  import lucky_ring_pkg::*;
#(
  parameter int N     = 8,
  parameter int WRAP  = 0,
  parameter int CHORD = 1,
  parameter int CW    = 8,
  localparam int W    = $clog2(N)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [W-1:0]  from,
  input  logic [W-1:0]  to,
  output logic [W-1:0]  blank,
  output logic [CW-1:0] moves,
  output logic          applied,
  output logic          solved,
  output logic          permutation
);

  logic [W-1:0]  r_board [N];
  logic [W-1:0]  r_freg;
  logic [W-1:0]  r_treg;
  logic [W-1:0]  r_blank;
  logic [CW-1:0] r_moves;
  logic          r_applied;

  logic              w_valid;
  logic              w_perm;
  logic [FLAT_W-1:0] w_flat;

  lucky_ring_puzzle_adj #(
    .N     (N),
    .WRAP  (WRAP),
    .CHORD (CHORD)
  ) u_adj (
    .i_freg  (r_freg),
    .i_treg  (r_treg),
    .i_blank (r_blank),
    .o_valid (w_valid)
  );

  // Request latch: sampled every edge, cleared by reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_freg <= '0;
      r_treg <= '0;
    end else begin
      r_freg <= from;
      r_treg <= to;
    end
  end

  // Board storage: reset to identity, otherwise slide one tile into the blank.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        r_board[i] <= W'(i);
      end
    end else if (w_valid) begin
      r_board[r_treg] <= r_board[r_freg];
      r_board[r_freg] <= '0;
    end
  end

  // Blank pointer follows the vacated cell so it always indexes the 0 tile.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_blank <= '0;
    end else if (w_valid) begin
      r_blank <= r_freg;
    end
  end

  // Saturating move counter and one-cycle applied pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_moves   <= '0;
      r_applied <= 1'b0;
    end else begin
      r_applied <= w_valid;
      if (w_valid && (r_moves != {CW{1'b1}})) begin
        r_moves <= r_moves + 1'b1;
      end
    end
  end

  // Pack the board into the fixed-width slot layout the solved check expects.
  always_comb begin
    w_flat = '0;
    for (int i = 0; i < N; i++) begin
      w_flat[i*MAX_IDX_W +: MAX_IDX_W] = MAX_IDX_W'(r_board[i]);
    end
  end

  // Permutation check: no two cells may hold the same tile.
  always_comb begin
    w_perm = 1'b1;
    for (int i = 0; i < N; i++) begin
      for (int j = i + 1; j < N; j++) begin
        if (r_board[i] == r_board[j]) begin
          w_perm = 1'b0;
        end
      end
    end
  end

  // Output drive.
  always_comb begin
    blank       = r_blank;
    moves       = r_moves;
    applied     = r_applied;
    solved      = identity_board(w_flat, N);
    permutation = w_perm;
  end

endmodule

// File: doc/lucky_ring_puzzle.md
Name: lucky_ring_puzzle

Overview:
- Parametrised successor to the eight-cell Lucky Seven model: an N-cell sliding-tile ring holding a permutation of 0..N-1, with tile 0 as the blank.
- Adds a configurable wrap edge (N-1 to 0), an optional chord (0 to N/2), synchronous reset, an explicit blank-position register, a saturating move counter, an applied-move pulse and a solved flag.
- Serves as a model-checking benchmark: the outputs are the state observables the properties refer to.

Parameters:
- N, 8, number of cells; power of two, at least 4. Local W = $clog2(N).
- WRAP, 0, 1 makes cells N-1 and 0 adjacent.
- CHORD, 1, 1 makes cells 0 and N/2 adjacent.
- CW, 8, width of the move counter.

Ports:
- clock  input  1  sole clock; all state updates on posedge.
- reset  input  1  synchronous, active-high.
- from  input  W  index of the cell whose tile is to slide.
- to  input  W  destination cell index.
- blank  output  W  registered index of the cell holding 0.
- moves  output  CW  registered count of applied moves; saturates.
- applied  output  1  registered pulse, high for one cycle after a move is applied.
- solved  output  1  combinational; board equals identity (b[i]==i for all i).
- permutation  output  1  combinational; all N entries pairwise distinct.

Behaviour:
- State: board b[0..N-1] (W bits each), freg, treg, blank, moves, applied.
- Reset, taking priority over any move at the same edge:
  - b[i]=i, freg=treg=0, blank=0, moves=0, applied=0.
  - Consequence: solved=1 and permutation=1 after reset.
- Input latch, every edge: freg<=from, treg<=to.
- A request sampled at edge k is evaluated and applied at edge k+1. Total latency from input setup to board change is 2 edges.
- valid (combinational on freg, treg, blank) requires both of:
  - treg==blank.
  - One adjacency term holds:
    - freg==treg+1 with no modulo, or treg==freg+1 with no modulo.
    - WRAP and {freg,treg}=={N-1,0} in either order.
    - CHORD and {freg,treg}=={0,N/2} in either order.
- freg==treg is never valid.
- valid is a function of freg/treg/blank only. Board contents are not consulted, so the model stays valid even with an illegal board.
- At an edge with valid and no reset:
  - b[treg]<=b[freg], b[freg]<=0, blank<=freg.
  - moves<=moves+1, or holds if all ones.
  - applied<=1.
- At an edge without valid: board, blank and moves hold; applied<=0.
- Holding from/to constant for many cycles applies the move at most once. After the move, blank==freg_old, so treg!=blank.
- Back-to-back requests, one per cycle, are each evaluated against the board updated by the previous edge. No bubble is required.
- The blank register must always equal the index of the 0 entry. This is an invariant for verification.

Decomposition:
- Package lucky_ring_pkg holds:
  - the function is_adjacent(f,t,N,WRAP,CHORD).
  - the function identity_board check.
- One sub-module is natural: lucky_ring_adj, a combinational adjacency/validity checker whose output is valid.
- Board storage, the counter and the outputs stay in the top module.

Test Plan:
All scenarios use N=8, WRAP=0, CHORD=1, CW=8 unless stated. "Apply" means drive from/to before edge e1; check results after e2.
- Reset then from=1,to=0 -> b[0]=1, b[1]=0, blank=1, moves=1, applied pulses 1 cycle, solved=0, permutation=1.
- After reset, from=4,to=0 (chord) -> b[0]=4, b[4]=0, blank=4, moves=1. Same test with CHORD=0 -> no change, moves=0, applied=0.
- After reset, from=7,to=0 -> rejected with WRAP=0 (moves=0); accepted with WRAP=1 (b[0]=7, blank=7). Also from=2,to=0 -> rejected, board unchanged.
- Apply 1->0, then 0->1 on consecutive cycles -> moves=2, board back to identity, solved=1, applied high 2 consecutive cycles.
- CW=2: alternate 1->0 and 0->1 five times -> moves sequence 1,2,3,3,3; board toggles correctly each time.
- Reset asserted at the edge where a valid 1->0 would apply -> board identity, moves=0, applied=0, blank=0. A held from=1,to=0 then applies 2 edges after reset deasserts.
